// File: rtl/fpu_pkg.sv
// Shared op indices, width defaults and FSM state type for the FP dispatch controller.
package fpu_pkg;
  localparam int FPU_NUM_UNITS = 9;
  localparam int FPU_DATA_W    = 32;
  localparam int FPU_CMP_W     = 6;
  localparam int FPU_TIMEOUT   = 255;

  localparam int FPU_ADD  = 0;
  localparam int FPU_SUB  = 1;
  localparam int FPU_MUL  = 2;
  localparam int FPU_DIV  = 3;
  localparam int FPU_SQRT = 4;
  localparam int FPU_ABS  = 5;
  localparam int FPU_CMP  = 6;
  localparam int FPU_FTOI = 7;
  localparam int FPU_ITOF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fpu_state_e;
endpackage

// File: rtl/fpu_watchdog.sv
// Cycle watchdog plus per-unit drain flags that swallow one late result after a timeout.
module fpu_watchdog
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS = FPU_NUM_UNITS,
  parameter int TIMEOUT   = FPU_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 active,
  input  logic                 fire,
  input  logic [NUM_UNITS-1:0] fire_onehot,
  input  logic [NUM_UNITS-1:0] unit_res_valid,
  output logic                 expired,
  output logic [NUM_UNITS-1:0] drain
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_UNITS-1:0] drain_q, drain_d;

  // Expiry is flagged one count early so the timeout edge lands TIMEOUT cycles after issue.
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign drain   = drain_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    drain_d = drain_q & ~unit_res_valid;
    if (fire) begin
      drain_d = drain_d | fire_onehot;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end
endmodule

// File: rtl/fpu_dispatch.sv
// Single-outstanding issue/return controller between the FP execute stage and NUM_UNITS FP units.
// Define FPU_TIMEOUT_EN to add the watchdog and drain logic (fpu_watchdog).
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS = FPU_NUM_UNITS,
  parameter int DATA_W    = FPU_DATA_W,
  parameter int OP_W      = $clog2(NUM_UNITS),
  parameter int CMP_W     = FPU_CMP_W,
  parameter int TIMEOUT   = FPU_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [OP_W-1:0]             req_op,
  input  logic [DATA_W-1:0]           req_a,
  input  logic [DATA_W-1:0]           req_b,
  input  logic [CMP_W-1:0]            req_c,
  output logic [DATA_W-1:0]           unit_a,
  output logic [DATA_W-1:0]           unit_b,
  output logic [CMP_W-1:0]            unit_c,
  output logic [NUM_UNITS-1:0]        unit_in_valid,
  input  logic [NUM_UNITS-1:0]        unit_in_ready,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_res_data,
  input  logic [NUM_UNITS-1:0]        unit_res_valid,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_W-1:0]           res_data,
  output logic                        res_err,
  output logic [1:0]                  dbg_state
);
  // All ports use valid/ready: a transfer happens on a rising edge where both are 1;
  // a producer holds valid and payload stable until that edge. unit_res_valid is a bare pulse.
  fpu_state_e           state_q, state_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic [CMP_W-1:0]     c_q, c_d;
  logic [NUM_UNITS-1:0] in_valid_q, in_valid_d;
  logic                 res_err_q, res_err_d;
  logic [NUM_UNITS-1:0] req_onehot, op_onehot, drain;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_ready, sel_res_valid, req_legal;
  logic                 accept, start, fire, expired;

  always_comb begin
    req_onehot    = '0;
    op_onehot     = '0;
    sel_data      = '0;
    sel_ready     = 1'b0;
    sel_res_valid = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (req_op == OP_W'(i)) req_onehot[i] = 1'b1;
      if (op_q == OP_W'(i)) begin
        op_onehot[i]  = 1'b1;
        sel_ready     = unit_in_ready[i];
        sel_res_valid = unit_res_valid[i];
        sel_data      = unit_res_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_legal = |req_onehot;
  // A legal op aimed at a unit still draining a stale result must wait in IDLE.
  assign req_ready = (state_q == IDLE) && !(|(req_onehot & drain));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    in_valid_d = in_valid_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    start      = 1'b0;
    fire       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          start = 1'b1;
          if (req_legal) begin
            op_d       = req_op;
            a_d        = req_a;
            b_d        = req_b;
            c_d        = req_c;
            in_valid_d = req_onehot;
            state_d    = ISSUE;
          end else begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = HOLD;
          end
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          in_valid_d = '0;
          if (sel_res_valid) begin
            res_data_d = sel_data;
            res_err_d  = 1'b0;
            state_d    = HOLD;
          end else begin
            state_d = WAIT;
          end
        end else if (expired) begin
          fire       = 1'b1;
          in_valid_d = '0;
          res_err_d  = 1'b1;
          res_data_d = '0;
          state_d    = HOLD;
        end
      end
      WAIT: begin
        if (sel_res_valid) begin
          res_data_d = sel_data;
          res_err_d  = 1'b0;
          state_d    = HOLD;
        end else if (expired) begin
          fire       = 1'b1;
          res_err_d  = 1'b1;
          res_data_d = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      in_valid_q <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      in_valid_q <= in_valid_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

`ifdef FPU_TIMEOUT_EN
  logic wd_active;
  assign wd_active = (state_q == ISSUE) || (state_q == WAIT);

  fpu_watchdog #(
    .NUM_UNITS(NUM_UNITS),
    .TIMEOUT  (TIMEOUT)
  ) u_watchdog (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .active        (wd_active),
    .fire          (fire),
    .fire_onehot   (op_onehot),
    .unit_res_valid(unit_res_valid),
    .expired       (expired),
    .drain         (drain)
  );
`else
  logic unused_wd;
  assign expired   = 1'b0;
  assign drain     = '0;
  assign unused_wd = ^{fire, start, op_onehot, TIMEOUT};
`endif

  assign unit_a        = a_q;
  assign unit_b        = b_q;
  assign unit_c        = c_q;
  assign unit_in_valid = in_valid_q;
  assign res_valid     = (state_q == HOLD);
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: directed cases plus randomized transactions vs a reference model.
module tb_fpu_dispatch;
  import fpu_pkg::*;

  localparam int NU = 9;
  localparam int DW = 32;
  localparam int OW = $clog2(NU);
  localparam int CW = 6;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid, req_ready;
  logic [OW-1:0]     req_op;
  logic [DW-1:0]     req_a, req_b;
  logic [CW-1:0]     req_c;
  logic [DW-1:0]     unit_a, unit_b;
  logic [CW-1:0]     unit_c;
  logic [NU-1:0]     unit_in_valid, unit_in_ready, unit_res_valid;
  logic [NU*DW-1:0]  unit_res_data;
  logic              res_valid, res_ready, res_err;
  logic [DW-1:0]     res_data;
  logic [1:0]        dbg_state;

  logic [DW-1:0]     exp_q[$];
  int                n_checks = 0;
  int                n_fail = 0;

  fpu_dispatch #(
    .NUM_UNITS(NU), .DATA_W(DW), .CMP_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
    .unit_in_valid(unit_in_valid), .unit_in_ready(unit_in_ready),
    .unit_res_data(unit_res_data), .unit_res_valid(unit_res_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural unit results: what each attached unit would hand back.
  function automatic logic [DW-1:0] unit_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [CW-1:0] c);
    case (int'(op))
      FPU_ADD:  return a + b;
      FPU_SUB:  return a - b;
      FPU_MUL:  return a * b;
      FPU_DIV:  return (b == 0) ? '1 : a / b;
      FPU_SQRT: return a >> 1;
      FPU_ABS:  return {1'b0, a[DW-2:0]};
      FPU_CMP:  return {{(DW-8){1'b0}}, 2'b00, c};
      default:  return a ^ b;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    req_valid      = 1'b0;
    req_op         = '0;
    req_a          = '0;
    req_b          = '0;
    req_c          = '0;
    unit_in_ready  = '0;
    unit_res_valid = '0;
    res_ready      = 1'b0;
  endtask

  task automatic fill_junk();
    for (int i = 0; i < NU; i++) unit_res_data[i*DW +: DW] = $urandom();
  endtask

  task automatic drive_result(input logic [OW-1:0] op, input logic [DW-1:0] val);
    fill_junk();
    unit_res_data[int'(op)*DW +: DW] = val;
    unit_res_valid[op] = 1'b1;
  endtask

  // One full transaction; called at a negedge, returns at a negedge.
  task automatic run_op(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] c, input int rdy_dly, input int lat,
                        input int hold_dly, input logic [DW-1:0] val, input bit spur);
    logic [NU-1:0] oh;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] sb_d;
    bit            legal;
    legal = (int'(op) < NU);
    oh = '0;
    if (legal) oh[op] = 1'b1;
    exp_d = legal ? val : '0;
    exp_q.push_back(exp_d);

    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c;
    #1 check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    if (legal) begin
      for (int k = 1; k <= 1 + rdy_dly; k++) begin
        @(negedge clk);
        check("in_valid_held", unit_in_valid, oh);
        check("res_valid_issue", res_valid, 0);
        check("req_ready_busy", req_ready, 0);
        if (k == 1) begin
          check("unit_a", unit_a, a);
          check("unit_b", unit_b, b);
          check("unit_c", unit_c, c);
        end
        if (k == 1 + rdy_dly) begin
          unit_in_ready[op] = 1'b1;
          if (lat == 0) drive_result(op, val);
        end
      end
      @(posedge clk); #1;
      unit_in_ready  = '0;
      unit_res_valid = '0;
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        check("in_valid_drop", unit_in_valid, 0);
        check("res_valid_wait", res_valid, 0);
        if (k == lat) drive_result(op, val);
        else if (spur && k == 1) drive_result(OW'((int'(op) + 1) % NU), $urandom());
        @(posedge clk); #1;
        unit_res_valid = '0;
      end
    end

    for (int h = 0; h <= hold_dly; h++) begin
      @(negedge clk);
      check("res_valid_hold", res_valid, 1);
      check("res_err", res_err, legal ? 0 : 1);
      check("in_valid_hold", unit_in_valid, 0);
      check("req_ready_hold", req_ready, 0);
      if (h < hold_dly) begin
        check("res_data_stable", res_data, exp_d);
      end else begin
        sb_d = exp_q.pop_front();
        check("res_data", res_data, sb_d);
        res_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_drop", res_valid, 0);
    check("res_err_clear", res_err, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    logic [CW-1:0] c;
    int            lat;

    idle_inputs();
    fill_junk();
    repeat (3) @(negedge clk);
    check("rst_in_valid", unit_in_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_res_data", res_data, 0);
    check("rst_unit_a", unit_a, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Directed: add with latency 3, illegal op, backpressure, zero-latency abs, div with spurious result.
    run_op(OW'(FPU_ADD), 32'h3F80_0000, 32'h4000_0000, '0, 0, 3, 0, 32'h4040_0000, 1'b0);
    run_op(OW'(12), 32'h1111_1111, 32'h2222_2222, 6'h3, 0, 0, 1, 32'h0, 1'b0);
    run_op(OW'(FPU_DIV), 32'h4100_0000, 32'h4000_0000, '0, 4, 2, 3, 32'h4080_0000, 1'b0);
    run_op(OW'(FPU_ABS), 32'hBF80_0000, '0, '0, 0, 0, 1, 32'h3F80_0000, 1'b0);
    run_op(OW'(FPU_DIV), 32'h4120_0000, 32'h4000_0000, '0, 0, 3, 0, 32'h40A0_0000, 1'b1);
    run_op(OW'(FPU_ITOF), 32'h0000_0007, '0, '0, 1, 1, 0, 32'h40E0_0000, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) op = OW'($urandom_range(NU, 15));
      else op = OW'($urandom_range(0, NU - 1));
      a   = $urandom();
      b   = $urandom();
      c   = CW'($urandom());
      lat = int'($urandom_range(0, 3));
      run_op(op, a, b, c, int'($urandom_range(0, 3)), lat, int'($urandom_range(0, 2)),
             unit_fn(op, a, b, c), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on a div; a stale result afterwards must be ignored.
    req_valid = 1'b1; req_op = OW'(FPU_DIV); req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_c = 6'h15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    unit_in_ready[FPU_DIV] = 1'b1;
    @(posedge clk); #1;
    unit_in_ready = '0;
    @(negedge clk);
    check("state_wait", dbg_state, WAIT);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_in_valid", unit_in_valid, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_unit_a", unit_a, 0);
    check("mid_rst_unit_b", unit_b, 0);
    check("mid_rst_unit_c", unit_c, 0);
    check("mid_rst_state", dbg_state, IDLE);
    @(negedge clk);
    rstn = 1'b1;
    drive_result(OW'(FPU_DIV), 32'h5555_AAAA);
    @(posedge clk); #1;
    unit_res_valid = '0;
    @(negedge clk);
    check("stale_res_ignored", res_valid, 0);
    check("stale_req_ready", req_ready, 1);
    run_op(OW'(FPU_DIV), 32'h4200_0000, 32'h4000_0000, '0, 0, 2, 0, 32'h4180_0000, 1'b0);

`ifdef FPU_TIMEOUT_EN
    // Div accepted but never answers: error result TIMEOUT+1 cycles after the request.
    req_valid = 1'b1; req_op = OW'(FPU_DIV); req_a = 32'h1; req_b = 32'h2; req_c = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("to_in_valid", unit_in_valid, 9'b0_0000_1000);
    unit_in_ready[FPU_DIV] = 1'b1;
    @(posedge clk); #1;
    unit_in_ready = '0;
    for (int k = 2; k <= TO; k++) begin
      @(negedge clk);
      check("to_res_valid_early", res_valid, 0);
    end
    @(negedge clk);
    check("to_res_valid", res_valid, 1);
    check("to_res_err", res_err, 1);
    check("to_res_data", res_data, 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = OW'(FPU_DIV);
    #1 check("drain_stall", req_ready, 0);
    @(negedge clk);
    check("drain_stall_hold", req_ready, 0);
    check("drain_no_issue", unit_in_valid, 0);
    req_valid = 1'b0;
    drive_result(OW'(FPU_DIV), 32'h7777_7777);
    @(posedge clk); #1;
    unit_res_valid = '0;
    @(negedge clk);
    check("late_res_ignored", res_valid, 0);
    run_op(OW'(FPU_DIV), 32'h4040_0000, 32'h3F80_0000, '0, 0, 2, 1, 32'h4040_0000, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
